sha256_block_builder: RTL and testbench
=======================================

Name: sha256_block_builder

Overview:
Upstream feeder for the SHA-256 compression core. It reads NUM_OF_WORDS 32-bit message words from memory and appends standard SHA-256 padding: a 0x80000000 word, zero fill, and the 64-bit bit-length. It emits one 16-word block at a time to the core over a valid/ready handshake. It is the only memory reader in the hash path; the core consumes only whole blocks.

Parameters:
NUM_OF_WORDS, 20, message length in 32-bit words (1..1024).
NONCE_IDX, 19, global word index overwritten by nonce (used only with the optional feature).

Ports:
clk  in  1  single clock for all logic.
reset_n  in  1  synchronous active-low reset.
start  in  1  pulse; accepted only in IDLE.
message_addr  in  16  base address of word 0.
nonce  in  32  nonce word; sampled when start is accepted; ignored without the macro.
mem_clk  out  1  equals clk.
mem_we  out  1  constant 0.
mem_addr  out  16  read address.
mem_read_data  in  32  read data, valid one cycle after its address.
blk_valid  out  1  blk_data holds a complete block.
blk_ready  in  1  core accepts the block.
blk_data  out  32 x 16  block words; index 0 is the first word.
blk_last  out  1  high with blk_valid on the final block.
blk_index  out  8  number of the block currently presented, from 0.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, reset_n low at a clk edge): state=IDLE; blk_valid=0, blk_last=0, blk_index=0, busy=0, mem_addr=0; buffer contents don't-care. Reset mid-operation abandons the message with no partial output.
- Block count: NB = (NUM_OF_WORDS+3+15)/16, rounded down. For global word index g = 16*blk + slot:
  - g < N: memory word.
  - g == N: 0x80000000.
  - Last block, slot 14: upper 32 bits of N*32.
  - Last block, slot 15: lower 32 bits of N*32.
  - Otherwise: 0.
- States: IDLE, FETCH, DRAIN, PRESENT.
  - IDLE: start -> FETCH; blk=0, slot=0, nonce latched.
  - FETCH: one slot per cycle for 16 cycles. mem_addr = message_addr + g. A slot with g >= N still takes one cycle, and its address is don't-care.
  - DRAIN: one cycle capturing the read for slot 15 -> PRESENT.
  - Capture pipeline: the word for slot s is written to buffer[s] one edge after its address was issued.
  - PRESENT: blk_valid=1; blk_data, blk_last and blk_index held stable until a transfer (blk_valid & blk_ready at the edge). After a transfer, blk_valid=0 in the same edge. If blk_last was set -> IDLE, otherwise blk++ -> FETCH.
- Latency: start accepted at edge E0 gives blk_valid=1 after edge E17. Each later block becomes valid 17 edges after the previous transfer.
- blk_ready while blk_valid=0 is ignored. start while busy is ignored.
- Address arithmetic is 16-bit and wraps modulo 2^16 without error. Length arithmetic is 64-bit.

Optional Feature:
SHA256_NONCE_INSERT_EN.
- Defined: the slot with g == NONCE_IDX takes the latched nonce instead of memory data. If NONCE_IDX >= N, the feature has no effect.
- Undefined: nonce port unused; every g < N comes from memory.

Decomposition:
- Package sha256_pkg holds:
  - word_t (32-bit) and block_t (16 x word_t).
  - PAD_WORD = 32'h80000000.
  - Function num_blocks(n).
  - The state enum type.
- One natural sub-module, sha256_pad_sel: combinational. Inputs g, slot, is_last, N, mem word and nonce; output the selected word.

Test Plan:
- N=13, words 0x00000001..0x0000000D:
  - one block with blk_last=1;
  - word13=0x80000000, word14=0, word15=0x000001A0;
  - blk_valid rises 17 cycles after start.
- N=16:
  - two blocks; block0 = memory words 0..15;
  - block1 word0=0x80000000, words 1..14=0, word15=0x00000200;
  - blk_last only on block1.
- N=20 with SHA256_NONCE_INSERT_EN, nonce=0xDEADBEEF:
  - block1 word3=0xDEADBEEF, word4=0x80000000, word15=0x00000280.
  - Without the macro, block1 word3 equals memory word 19.
- Backpressure: hold blk_ready=0 for 10 cycles while blk_valid=1 -> blk_data, blk_last and blk_index are unchanged every cycle, and there are no mem_addr changes.
- Reset mid-FETCH (slot 7 of block0), then start again -> state IDLE, blk_valid=0, busy=0; the restart produces a correct block0 from slot 0.
- start pulsed while in PRESENT -> ignored; the block sequence and blk_index values are unchanged.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared types and helpers for the SHA-256 block builder.
package sha256_pkg;

    typedef logic [31:0] word_t;
    typedef word_t [15:0] block_t;

    localparam word_t PAD_WORD = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        PRESENT
    } state_e;

    // One pad word plus two length words must fit after the message.
    function automatic int unsigned num_blocks(input int unsigned n);
        return (n + 3 + 15) / 16;
    endfunction

endpackage

// File: rtl/sha256_pad_sel.sv
// Chooses the word stored in one block slot: message data, the pad
// marker, the 64-bit bit length, or zero fill.
// With SHA256_NONCE_INSERT_EN defined, the word at global index
// NONCE_IDX is replaced by the latched nonce when it lies inside the message.
module sha256_pad_sel
    import sha256_pkg::*;
#(
    parameter int unsigned NONCE_IDX = 19
) (
    input  logic [15:0] g_i,
    input  logic [3:0]  slot_i,
    input  logic        is_last_i,
    input  logic [15:0] n_words_i,
    input  word_t       mem_word_i,
    input  word_t       nonce_i,
    output word_t       word_o
);

    logic [63:0] bit_len;

`ifndef SHA256_NONCE_INSERT_EN
    logic unused_nonce;
    assign unused_nonce = ^{nonce_i, NONCE_IDX};
`endif

    // Priority: message words, then the pad marker, then length in the last block.
    always_comb begin
        bit_len = 64'(n_words_i) << 5;
        word_o  = '0;
        if (g_i < n_words_i) begin
            word_o = mem_word_i;
`ifdef SHA256_NONCE_INSERT_EN
            if (32'(g_i) == NONCE_IDX) begin
                word_o = nonce_i;
            end
`endif
        end else if (g_i == n_words_i) begin
            word_o = PAD_WORD;
        end else if (is_last_i && slot_i == 4'd14) begin
            word_o = bit_len[63:32];
        end else if (is_last_i && slot_i == 4'd15) begin
            word_o = bit_len[31:0];
        end
    end

endmodule

// File: rtl/sha256_block_builder.sv
// Reads a fixed-length message from memory, appends SHA-256 padding and
// hands 16-word blocks to the compression core over valid/ready.
// Optional feature macro: SHA256_NONCE_INSERT_EN (nonce word substitution).
module sha256_block_builder
    import sha256_pkg::*;
#(
    parameter int unsigned NUM_OF_WORDS = 20,
    parameter int unsigned NONCE_IDX    = 19
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] message_addr,
    input  logic [31:0] nonce,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    input  logic [31:0] mem_read_data,
    output logic        blk_valid,
    input  logic        blk_ready,
    output block_t      blk_data,
    output logic        blk_last,
    output logic [7:0]  blk_index,
    output logic        busy
);

    localparam int unsigned NB       = num_blocks(NUM_OF_WORDS);
    localparam logic [7:0]  LAST_BLK = 8'(NB - 1);
    localparam logic [15:0] N_WORDS  = 16'(NUM_OF_WORDS);

    state_e      state_q, state_d;
    logic [7:0]  blk_q, blk_d;
    logic [3:0]  slot_q, slot_d;
    logic [3:0]  cap_slot_q;
    logic        cap_en_q;
    logic [15:0] base_q;
    word_t       nonce_q;
    block_t      buf_q;
    word_t       sel_word;
    logic [15:0] fetch_g;
    logic [15:0] cap_g;
    logic        is_last_blk;

    assign mem_clk     = clk;
    assign mem_we      = 1'b0;
    assign fetch_g     = {4'b0, blk_q, slot_q};
    assign cap_g       = {4'b0, blk_q, cap_slot_q};
    assign is_last_blk = (blk_q == LAST_BLK);
    assign blk_data    = buf_q;
    assign blk_index   = blk_q;

    // Control registers: state, block number and fetch slot.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            blk_q   <= '0;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            slot_q  <= slot_d;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d   = state_q;
        blk_d     = blk_q;
        slot_d    = slot_q;
        blk_valid = 1'b0;
        blk_last  = 1'b0;
        busy      = 1'b1;
        mem_addr  = '0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = FETCH;
                    blk_d   = '0;
                    slot_d  = '0;
                end
            end
            FETCH: begin
                mem_addr = base_q + fetch_g;
                slot_d   = slot_q + 4'd1;
                if (slot_q == 4'd15) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = PRESENT;
            end
            PRESENT: begin
                blk_valid = 1'b1;
                blk_last  = is_last_blk;
                if (blk_ready) begin
                    if (is_last_blk) begin
                        state_d = IDLE;
                    end else begin
                        state_d = FETCH;
                        blk_d   = blk_q + 8'd1;
                        slot_d  = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture pipeline tracking which slot's read data arrives next, plus start-time latches.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cap_en_q   <= 1'b0;
            cap_slot_q <= '0;
            base_q     <= '0;
            nonce_q    <= '0;
        end else begin
            cap_en_q   <= (state_q == FETCH);
            cap_slot_q <= slot_q;
            if (state_q == IDLE && start) begin
                base_q  <= message_addr;
                nonce_q <= nonce;
            end
        end
    end

    // Block buffer: each slot written one edge after its read data is valid.
    always_ff @(posedge clk) begin
        if (reset_n && cap_en_q) begin
            buf_q[cap_slot_q] <= sel_word;
        end
    end

    sha256_pad_sel #(
        .NONCE_IDX (NONCE_IDX)
    ) u_pad_sel (
        .g_i        (cap_g),
        .slot_i     (cap_slot_q),
        .is_last_i  (is_last_blk),
        .n_words_i  (N_WORDS),
        .mem_word_i (mem_read_data),
        .nonce_i    (nonce_q),
        .word_o     (sel_word)
    );

endmodule

// File: tb/tb_sha256_block_builder.sv
// Drives three builders (13, 16 and 20 word messages) from a shared random
// memory and compares every delivered block against a padded-message model.
`timescale 1ns/1ps
module tb_sha256_block_builder;
    import sha256_pkg::*;

    localparam int NINST     = 3;
    localparam int NONCE_POS = 19;

    typedef struct packed {
        block_t     data;
        logic       last;
        logic [7:0] idx;
    } expBlk_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        hold = 1'b0;
    logic        startv   [NINST];
    logic [15:0] msgAddr  [NINST];
    logic [31:0] nonceV   [NINST];
    logic        rdy      [NINST];
    logic        memClk   [NINST];
    logic        memWe    [NINST];
    logic [15:0] memAddr  [NINST];
    logic        blkValid [NINST];
    logic        blkLast  [NINST];
    logic        busyV    [NINST];
    block_t      blkData  [NINST];
    logic [7:0]  blkIdx   [NINST];
    logic [31:0] memArr   [0:65535];
    expBlk_t     expQ     [NINST][$];
    int          msgLen   [NINST] = '{13, 16, 20};

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic        validPrev [NINST];
    logic        xferPrev  [NINST];
    logic        postReset [NINST];
    block_t      prevData  [NINST];
    logic        prevLast  [NINST];
    logic [7:0]  prevIdx   [NINST];
    logic [15:0] prevAddr  [NINST];
    int          lastEvent [NINST];

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    for (genvar k = 0; k < NINST; k++) begin : gDut
        logic [31:0] rd;
        always @(posedge clk) rd <= memArr[memAddr[k]];
        sha256_block_builder #(
            .NUM_OF_WORDS (k == 0 ? 13 : (k == 1 ? 16 : 20)),
            .NONCE_IDX    (NONCE_POS)
        ) dut (
            .clk           (clk),
            .reset_n       (reset_n),
            .start         (startv[k]),
            .message_addr  (msgAddr[k]),
            .nonce         (nonceV[k]),
            .mem_clk       (memClk[k]),
            .mem_we        (memWe[k]),
            .mem_addr      (memAddr[k]),
            .mem_read_data (rd),
            .blk_valid     (blkValid[k]),
            .blk_ready     (rdy[k]),
            .blk_data      (blkData[k]),
            .blk_last      (blkLast[k]),
            .blk_index     (blkIdx[k]),
            .busy          (busyV[k])
        );
    end

    // Random consumer readiness, forced low while hold is set.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < NINST; k++) begin
            rdy[k] = hold ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    task automatic checkOutput(input string name, input int k,
                               input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s dut%0d: got %0h expected %0h", name, k, act, exp);
        end
    endtask

    // Reference: full padded message as a flat word list, cut into blocks.
    function automatic void pushMessage(input int k);
        int          n  = msgLen[k];
        int          nb = (n + 3 + 15) / 16;
        logic [31:0] words[$];
        logic [63:0] bits;
        logic [15:0] a;
        expBlk_t     e;
        for (int i = 0; i < n; i++) begin
            a = msgAddr[k] + 16'(i);
            words.push_back(memArr[a]);
`ifdef SHA256_NONCE_INSERT_EN
            if (i == NONCE_POS) words[i] = nonceV[k];
`endif
        end
        words.push_back(32'h8000_0000);
        while (words.size() < nb * 16 - 2) words.push_back(32'h0);
        bits = 64'(n) * 64'd32;
        words.push_back(bits[63:32]);
        words.push_back(bits[31:0]);
        for (int b = 0; b < nb; b++) begin
            for (int s = 0; s < 16; s++) e.data[s] = words[b * 16 + s];
            e.last = (b == nb - 1);
            e.idx  = 8'(b);
            expQ[k].push_back(e);
        end
    endfunction

    // Pulse start on the selected instances; push expectations only when acceptance is intended.
    task automatic applyStimulus(input logic [2:0] mask, input logic push);
        @(posedge clk);
        #1;
        for (int k = 0; k < NINST; k++) begin
            if (mask[k]) begin
                if (push) begin
                    msgAddr[k] = ($urandom_range(0, 3) == 0) ? 16'hFFF8 : 16'($urandom);
                    nonceV[k]  = $urandom;
                    pushMessage(k);
                end
                startv[k] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NINST; k++) startv[k] = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n    = 0;
        bit done = 0;
        while (!done && n < budget) begin
            @(posedge clk);
            #2;
            n++;
            done = 1;
            for (int k = 0; k < NINST; k++) begin
                if (busyV[k] !== 1'b0 || expQ[k].size() != 0) done = 0;
            end
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL idle_timeout: still busy after %0d cycles, required idle", budget);
        end
    endtask

    task automatic waitValid(input int k, input int budget);
        int n = 0;
        while (blkValid[k] !== 1'b1 && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (blkValid[k] !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL valid_timeout dut%0d: blk_valid=%b, required 1", k, blkValid[k]);
        end
    endtask

    // Monitor: reset state, stall stability, latency and scoreboard pops on each transfer.
    always @(negedge clk) begin
        for (int k = 0; k < NINST; k++) begin
            expBlk_t e;
            logic    xfer;
            xfer = (blkValid[k] === 1'b1) && (rdy[k] === 1'b1) && reset_n;
            if (postReset[k]) begin
                checkOutput("reset_valid", k, 512'(blkValid[k]), 512'(0));
                checkOutput("reset_busy", k, 512'(busyV[k]), 512'(0));
                checkOutput("reset_last", k, 512'(blkLast[k]), 512'(0));
                checkOutput("reset_index", k, 512'(blkIdx[k]), 512'(0));
                checkOutput("reset_addr", k, 512'(memAddr[k]), 512'(0));
                checkOutput("mem_we", k, 512'(memWe[k]), 512'(0));
                checkOutput("mem_clk", k, 512'(memClk[k]), 512'(clk));
                postReset[k] = 1'b0;
            end else begin
                if (validPrev[k] && !xferPrev[k]) begin
                    checkOutput("stall_valid", k, 512'(blkValid[k]), 512'(1));
                    if (blkValid[k] === 1'b1) begin
                        checkOutput("stall_data", k, blkData[k], prevData[k]);
                        checkOutput("stall_last", k, 512'(blkLast[k]), 512'(prevLast[k]));
                        checkOutput("stall_index", k, 512'(blkIdx[k]), 512'(prevIdx[k]));
                        checkOutput("stall_addr", k, 512'(memAddr[k]), 512'(prevAddr[k]));
                    end
                end
                if (blkValid[k] === 1'b1 && !validPrev[k]) begin
                    checkOutput("latency", k, 512'(cyc - lastEvent[k]), 512'(17));
                end
            end
            if (xfer) begin
                if (expQ[k].size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL extra_block dut%0d: got index %0d, required no block", k, blkIdx[k]);
                end else begin
                    e = expQ[k].pop_front();
                    checkOutput("blk_data", k, blkData[k], e.data);
                    checkOutput("blk_last", k, 512'(blkLast[k]), 512'(e.last));
                    checkOutput("blk_index", k, 512'(blkIdx[k]), 512'(e.idx));
                end
                lastEvent[k] = cyc + 1;
            end
            if (startv[k] === 1'b1 && busyV[k] === 1'b0 && reset_n) lastEvent[k] = cyc + 1;
            validPrev[k] = (blkValid[k] === 1'b1);
            xferPrev[k]  = xfer;
            prevData[k]  = blkData[k];
            prevLast[k]  = blkLast[k];
            prevIdx[k]   = blkIdx[k];
            prevAddr[k]  = memAddr[k];
            if (!reset_n) begin
                expQ[k].delete();
                postReset[k] = 1'b1;
                validPrev[k] = 1'b0;
                xferPrev[k]  = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence: plain runs, backpressure, mid-fetch reset, start while presenting, random runs.
    initial begin
        reset_n = 1'b0;
        for (int k = 0; k < NINST; k++) begin
            startv[k]    = 1'b0;
            msgAddr[k]   = '0;
            nonceV[k]    = '0;
            validPrev[k] = 1'b0;
            xferPrev[k]  = 1'b0;
            postReset[k] = 1'b0;
            lastEvent[k] = 0;
        end
        for (int i = 0; i < 65536; i++) memArr[i] = $urandom;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        $display("[TB] basic messages");
        applyStimulus(3'b111, 1'b1);
        waitIdle(300);

        $display("[TB] backpressure");
        hold = 1'b1;
        applyStimulus(3'b111, 1'b1);
        waitValid(2, 40);
        repeat (10) @(posedge clk);
        hold = 1'b0;
        waitIdle(300);

        $display("[TB] reset during fetch");
        applyStimulus(3'b111, 1'b1);
        repeat (8) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        applyStimulus(3'b111, 1'b1);
        waitIdle(300);

        $display("[TB] start while presenting");
        hold = 1'b1;
        applyStimulus(3'b111, 1'b1);
        waitValid(2, 40);
        applyStimulus(3'b111, 1'b0);
        repeat (4) @(posedge clk);
        hold = 1'b0;
        waitIdle(300);

        $display("[TB] random messages");
        for (int r = 0; r < 8; r++) begin
            applyStimulus(3'($urandom_range(1, 7)), 1'b1);
            waitIdle(300);
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
